// File: rtl/ring_phase_dec_pkg.sv
// ring_pkg: state encoding and width helper shared by the ring phase decoder files.
package ring_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_TRACK  = ST_TRACK,
    S_LOCKED = ST_LOCKED,
    S_FAULT  = ST_FAULT
  } state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ring_phase_dec_if.sv
// ring_phase_dec_if: ring sample inputs and decoded outputs; err_cnt exists only with RING_PHASE_DEC_ERR_CNT_EN.
interface ring_phase_dec_if import ring_pkg::*; #(
  parameter int N     = 4,
  parameter int REV_W = 8
);
  logic [N-1:0]          ring_in;
  logic                  en;
  logic                  clr;
  logic [idx_w(N)-1:0]   phase;
  logic                  phase_vld;
  logic                  locked;
  logic [REV_W-1:0]      rev_cnt;
  logic                  err;
`ifdef RING_PHASE_DEC_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif
  modport master (
    output ring_in, en, clr,
    input  phase, phase_vld, locked, rev_cnt, err
`ifdef RING_PHASE_DEC_ERR_CNT_EN
    , input err_cnt
`endif
  );
  modport slave (
    input  ring_in, en, clr,
    output phase, phase_vld, locked, rev_cnt, err
`ifdef RING_PHASE_DEC_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/ring_phase_dec_onehot_enc.sv
// onehot_enc: flags an exactly-one-bit-set ring sample and returns the set bit position.
module onehot_enc import ring_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]        ring_in,
  output logic                onehot,
  output logic [idx_w(N)-1:0] idx
);
  localparam int PW = idx_w(N);
  assign onehot = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) if (ring_in[i]) idx = PW'(i);
  end
endmodule

// File: rtl/ring_phase_dec.sv
// ring_phase_dec: one-hot ring monitor producing phase, lock, revolution count and sticky error.
// Define RING_PHASE_DEC_ERR_CNT_EN to add the saturating LOCKED->FAULT counter err_cnt.
module ring_phase_dec import ring_pkg::*; #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4,
  parameter int REV_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  ring_phase_dec_if.slave  bus
);
  localparam int PW = idx_w(N);
  localparam int GW = idx_w(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);
  state_t           state, state_n;
  logic [GW-1:0]    good, good_n;
  logic [PW-1:0]    idx, phase_q, next_idx;
  logic [REV_W-1:0] rev_q;
  logic             onehot, step_ok, sample, to_fault, rev_inc, vld_q, err_q;
  onehot_enc #(.N(N)) u_enc (.ring_in(bus.ring_in), .onehot(onehot), .idx(idx));
  assign sample   = bus.en && !bus.clr;
  assign next_idx = (phase_q == PW'(N - 1)) ? '0 : phase_q + 1'b1;
  assign step_ok  = onehot && (idx == next_idx);
  assign rev_inc  = sample && (state == S_LOCKED) && step_ok && (idx == '0);
  always_comb begin
    state_n  = state;
    good_n   = good;
    to_fault = 1'b0;
    if (sample) begin
      case (state)
        S_IDLE, S_FAULT: begin
          state_n = onehot ? S_TRACK : S_IDLE;
          good_n  = '0;
        end
        S_TRACK: begin
          good_n  = step_ok ? good + 1'b1 : '0;
          state_n = step_ok ? ((good_n == LOCK_TGT) ? S_LOCKED : S_TRACK)
                            : (onehot ? S_TRACK : S_IDLE);
        end
        S_LOCKED: begin
          state_n  = step_ok ? S_LOCKED : S_FAULT;
          to_fault = !step_ok;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      good    <= '0;
      phase_q <= '0;
      vld_q   <= 1'b0;
      rev_q   <= '0;
      err_q   <= 1'b0;
    end else if (bus.clr) begin
      state <= S_IDLE;
      good  <= '0;
      vld_q <= 1'b0;
      rev_q <= '0;
      err_q <= 1'b0;
    end else if (bus.en) begin
      state <= state_n;
      good  <= good_n;
      vld_q <= onehot;
      if (onehot) phase_q <= idx;
      rev_q <= rev_q + REV_W'(rev_inc);
      err_q <= err_q | to_fault;
    end
  end
`ifdef RING_PHASE_DEC_ERR_CNT_EN
  logic [7:0] ecnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ecnt <= '0;
    else if (bus.clr) ecnt <= '0;
    else if (to_fault && ecnt != 8'hFF) ecnt <= ecnt + 1'b1;
  end
  assign bus.err_cnt = ecnt;
`endif
  assign bus.phase     = phase_q;
  assign bus.phase_vld = vld_q;
  assign bus.locked    = (state == S_LOCKED);
  assign bus.rev_cnt   = rev_q;
  assign bus.err       = err_q;
endmodule
